// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and the matching receiver).
// Contents:
//   tx_state_e     - transmit FSM states
//   OVERSAMPLE_DEF - default tick_i pulses per bit period
//   DBITS_5..8     - data_bit_num encodings
//   data_width()   - maps a 2-bit data_bit_num code to a bit count (5..8)
//   PARITY_ODD/EVEN- parity_type encodings
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam logic PARITY_ODD  = 1'b0;
  localparam logic PARITY_EVEN = 1'b1;

  // 00 -> 5 ... 11 -> 8 data bits.
  function automatic logic [3:0] data_width(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_tx_shift_register.sv
// 8-bit parallel-in / serial-out shift register for the UART transmitter.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   load_en_i    - load data_i (has priority over shift)
//   shift_en_i   - shift right by one, zero filling from the top
//   data_i [7:0] - parallel load value
//   ser_o        - current serial bit (bit 0)
module uart_tx_shift_register
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en_i,
  input  logic       shift_en_i,
  input  logic [7:0] data_i,
  output logic       ser_o
);

  logic [7:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_en_i) begin
      data_q <= data_i;
    end else if (shift_en_i) begin
      data_q <= {1'b0, data_q[7:1]};
    end
  end

  assign ser_o = data_q[0];

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit engine: accepts one character per valid/ready handshake and
// sends it LSB-first as start bit, 5-8 data bits, optional parity, 1-2 stop
// bits. Each bit lasts OVERSAMPLE pulses of tick_i.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   tick_i          - baud oversample strobe (one clk wide)
//   tx_en_i         - transmitter enable
//   cts_ni          - clear-to-send, active low
//   data_bit_num_i  - 00=5 .. 11=8 data bits
//   parity_en_i     - parity bit present
//   parity_type_i   - 0=odd, 1=even
//   stop_bit_num_i  - 0=one, 1=two stop bits
//   data_i          - character (bits above selected width ignored)
//   data_i_valid    - data_i valid
//   ready_o         - can accept a character
//   tx_o            - serial line, idle high
//   busy_o          - frame in progress
//   tx_done_o       - one-clk pulse in the first idle cycle after a frame
//   state_o         - current FSM state (debug visibility)
//
// Handshake: a character is transferred on a rising clk edge where both
// data_i_valid and ready_o are high. ready_o only depends on state, tx_en_i,
// cts_ni and reset, never on data_i_valid. Once accepted, the frame always
// completes (unless reset); tx_en_i/cts_ni only gate new accepts.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       tx_en_i,
  input  logic       cts_ni,
  input  logic [1:0] data_bit_num_i,
  input  logic       parity_en_i,
  input  logic       parity_type_i,
  input  logic       stop_bit_num_i,
  input  logic [7:0] data_i,
  input  logic       data_i_valid,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output tx_state_e  state_o
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  tx_state_e  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] last_bit_q, last_bit_d;
  logic       par_en_q;
  logic       stop2_q;
  logic       parity_bit_q, parity_bit_d;
  logic       done_q, done_d;

  logic       accept;
  logic       bit_end;
  logic       load_en;
  logic       shift_en;
  logic       ser_bit;
  logic [7:0] data_mask;

  uart_tx_shift_register u_shift (
    .clk        (clk),
    .reset      (reset),
    .load_en_i  (load_en),
    .shift_en_i (shift_en),
    .data_i     (data_i),
    .ser_o      (ser_bit)
  );

  // Gated by reset so ready_o stays low for as long as reset is held.
  assign ready_o = ~reset & tx_en_i & ~cts_ni & (state_q == TX_IDLE);
  assign accept  = data_i_valid & ready_o;
  assign bit_end = tick_i & (tick_cnt_q == TICK_LAST);

  // Parity is computed from the character at accept time, so the shift
  // register does not need to retain the original data.
  assign data_mask    = 8'hFF >> (2'd3 - data_bit_num_i);
  assign parity_bit_d = (^(data_i & data_mask)) ^ ~parity_type_i;
  assign last_bit_d   = 3'(data_width(data_bit_num_i) - 4'd1);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    done_d     = 1'b0;
    tx_o       = 1'b1;

    if (tick_i) begin
      tick_cnt_d = bit_end ? 4'd0 : tick_cnt_q + 4'd1;
    end

    case (state_q)
      TX_IDLE: begin
        // A tick in the accept cycle is not counted toward the start bit.
        tick_cnt_d = 4'd0;
        if (accept) begin
          load_en   = 1'b1;
          bit_cnt_d = 3'd0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        tx_o = 1'b0;
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_o = ser_bit;
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_cnt_q == last_bit_q) begin
            bit_cnt_d = 3'd0;
            state_d   = par_en_q ? TX_PARITY : TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      TX_PARITY: begin
        tx_o = parity_bit_q;
        if (bit_end) state_d = TX_STOP;
      end
      TX_STOP: begin
        tx_o = 1'b1;
        // bit_cnt reused to count stop bits.
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == 3'd0)) begin
            bit_cnt_d = 3'd1;
          end else begin
            bit_cnt_d = 3'd0;
            done_d    = 1'b1;
            state_d   = TX_IDLE;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TX_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      last_bit_q   <= '0;
      par_en_q     <= 1'b0;
      stop2_q      <= 1'b0;
      parity_bit_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
      if (load_en) begin
        last_bit_q   <= last_bit_d;
        par_en_q     <= parity_en_i;
        stop2_q      <= stop_bit_num_i;
        parity_bit_q <= parity_bit_d;
      end
    end
  end

  assign busy_o    = (state_q != TX_IDLE);
  assign tx_done_o = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;
  import uart_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_i = 1'b0;
  logic       tx_en_i = 1'b1;
  logic       cts_ni = 1'b0;
  logic [1:0] data_bit_num_i = 2'b11;
  logic       parity_en_i = 1'b0;
  logic       parity_type_i = 1'b0;
  logic       stop_bit_num_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       data_i_valid = 1'b0;
  logic       ready_o, tx_o, busy_o, tx_done_o;
  tx_state_e  state_o;

  always #5 clk = ~clk;

  uart_transmitter #(.OVERSAMPLE(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .tick_i         (tick_i),
    .tx_en_i        (tx_en_i),
    .cts_ni         (cts_ni),
    .data_bit_num_i (data_bit_num_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .stop_bit_num_i (stop_bit_num_i),
    .data_i         (data_i),
    .data_i_valid   (data_i_valid),
    .ready_o        (ready_o),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .tx_done_o      (tx_done_o),
    .state_o        (state_o)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int         done_cnt = 0;
  int         tick_div = 0;

  // Tick every 4th clock, driven on the falling edge. In the same step the
  // line is recorded for every tick the DUT will consume while busy, so
  // each bit period contributes exactly 16 samples.
  initial begin
    forever begin
      @(negedge clk);
      tick_i   = (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
      if (tx_done_o) done_cnt++;
      if (tick_i && busy_o) got_q.push_back(tx_o);
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] d, input string name);
    int n;
    n = 0;
    data_i       = d;
    data_i_valid = 1'b1;
    #1;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " accept"}, ready_o, 1'b1);
    @(negedge clk);
    data_i_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!tx_done_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " done"}, tx_done_o, 1'b1);
  endtask

  task automatic push_seq(input logic [11:0] seq, input int nb);
    logic [11:0] s;
    s = seq;
    for (int i = 0; i < nb; i++) exp_q.push_back(s[11-i]);
  endtask

  task automatic compare_frames(input string name);
    int nexp;
    int bad;
    logic [0:0] e;
    nexp = exp_q.size();
    check({name, " tick count"}, got_q.size(), nexp * 16);
    for (int b = 0; b < nexp; b++) begin
      e   = exp_q.pop_front();
      bad = 0;
      for (int k = 0; k < 16; k++) begin
        if (b * 16 + k >= got_q.size()) bad++;
        else if (got_q[b*16+k] !== e) bad++;
      end
      check($sformatf("%s bit%0d wrong samples", name, b), bad, 0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [1:0]  dcode;
    logic        pen;
    logic        ptype;
    logic        stop2;
    logic [7:0]  data;
    int          nb;
    logic [11:0] seq;   // transmitted bits, first bit in [11]
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"8N1_55", DBITS_8, 1'b0, PARITY_ODD,  1'b0, 8'h55, 10, 12'b0101010101_00};
    vecs[1] = '{"5E1_FF", DBITS_5, 1'b1, PARITY_EVEN, 1'b0, 8'hFF,  8, 12'b01111111_0000};
    vecs[2] = '{"7O2_41", DBITS_7, 1'b1, PARITY_ODD,  1'b1, 8'h41, 11, 12'b01000001111_0};
    vecs[3] = '{"6O1_00", DBITS_6, 1'b1, PARITY_ODD,  1'b0, 8'h00,  9, 12'b000000011_000};
    vecs[4] = '{"8E2_80", DBITS_8, 1'b1, PARITY_EVEN, 1'b1, 8'h80, 12, 12'b000000001111};

    // ---- reset state ----
    repeat (5) @(negedge clk);
    check("reset tx_o", tx_o, 1'b1);
    check("reset busy_o", busy_o, 1'b0);
    check("reset ready_o", ready_o, 1'b0);
    check("reset tx_done_o", tx_done_o, 1'b0);
    check("reset state", state_o, TX_IDLE);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("idle ready_o", ready_o, 1'b1);

    // ---- table-driven frames ----
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      data_bit_num_i = vecs[v].dcode;
      parity_en_i    = vecs[v].pen;
      parity_type_i  = vecs[v].ptype;
      stop_bit_num_i = vecs[v].stop2;
      got_q.delete();
      push_seq(vecs[v].seq, vecs[v].nb);
      send(vecs[v].data, vecs[v].name);
      check({vecs[v].name, " latency tx_o"}, tx_o, 1'b0);
      check({vecs[v].name, " busy"}, busy_o, 1'b1);
      check({vecs[v].name, " ready low"}, ready_o, 1'b0);
      // Configuration changes mid-frame must not affect the frame.
      data_bit_num_i = ~vecs[v].dcode;
      parity_en_i    = ~vecs[v].pen;
      parity_type_i  = ~vecs[v].ptype;
      stop_bit_num_i = ~vecs[v].stop2;
      data_i         = ~vecs[v].data;
      wait_done(vecs[v].name);
      check({vecs[v].name, " busy at done"}, busy_o, 1'b0);
      check({vecs[v].name, " ready at done"}, ready_o, 1'b1);
      @(negedge clk);
      check({vecs[v].name, " done pulse width"}, tx_done_o, 1'b0);
      compare_frames(vecs[v].name);
    end

    // ---- back-to-back 0xA5 then 0x3C, valid held high ----
    data_bit_num_i = DBITS_8;
    parity_en_i    = 1'b0;
    stop_bit_num_i = 1'b0;
    got_q.delete();
    push_seq(12'b0101001011_00, 10);
    push_seq(12'b0001111001_00, 10);
    send(8'hA5, "b2b first");
    data_i       = 8'h3C;
    data_i_valid = 1'b1;
    wait_done("b2b first");
    check("b2b ready at done", ready_o, 1'b1);
    @(negedge clk);
    data_i_valid = 1'b0;
    check("b2b second start", tx_o, 1'b0);
    check("b2b second busy", busy_o, 1'b1);
    wait_done("b2b second");
    @(negedge clk);
    compare_frames("b2b");

    // ---- flow control ----
    begin
      int viol;
      viol = 0;
      got_q.delete();
      cts_ni       = 1'b1;
      data_i       = 8'h55;
      data_i_valid = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (ready_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) viol++;
      end
      check("cts blocked cycles", viol, 0);
      push_seq(12'b0101010101_00, 10);
      cts_ni = 1'b0;
      @(negedge clk);
      data_i_valid = 1'b0;
      check("cts release start", tx_o, 1'b0);
      repeat (100) @(negedge clk);
      cts_ni  = 1'b1;
      tx_en_i = 1'b0;
      wait_done("cts midframe");
      check("cts midframe ready low", ready_o, 1'b0);
      @(negedge clk);
      compare_frames("cts midframe");
      cts_ni  = 1'b0;
      tx_en_i = 1'b1;
    end

    // ---- reset during DATA ----
    begin
      int d0;
      @(negedge clk);
      send(8'hF0, "rst frame");
      repeat (200) @(negedge clk);
      check("rst in DATA", state_o, TX_DATA);
      d0    = done_cnt;
      reset = 1'b1;
      @(negedge clk);
      check("rst tx_o", tx_o, 1'b1);
      check("rst busy_o", busy_o, 1'b0);
      check("rst ready_o", ready_o, 1'b0);
      check("rst state", state_o, TX_IDLE);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("rst no done pulse", done_cnt, d0);
      check("rst ready after", ready_o, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
